id_ex_reg: RTL
==============

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/PC width.
REQ-002 SHALL have parameter RADDR_W, default 4, register-index width.
REQ-003 SHALL have ports: clk in 1, rising-edge clock; rst in 1, reset, one clock, asynchronous, active-low.
REQ-004 SHALL have inputs: freeze in 1 hold all state; flush in 1 insert bubble; pc_in in DATA_W; val_rn_in, val_rm_in in DATA_W operands from register file; src1_in, src2_in, dest_in in RADDR_W; exe_cmd_in in 4; mem_r_en_in, mem_w_en_in, wb_en_in, s_in, b_in, imm_in in 1 each; shift_operand_in in 12; signed_imm24_in in 24; status_in in 4 (NZCV).
REQ-005 SHALL have write-back snoop inputs: wb_dest in RADDR_W; wb_value in DATA_W; wb_we in 1.
REQ-006 SHALL have registered outputs: one *_out per captured input above, plus valid_out 1.

Function
REQ-007 SHALL capture all *_in on rising clk when freeze=0 and flush=0, with valid_out=1 the next cycle; latency exactly one cycle.
REQ-008 SHALL, when flush=1 and freeze=0, load a bubble: wb_en, mem_r_en, mem_w_en, s, b, valid_out = 0; exe_cmd=0; dest=0; data fields = 0.
REQ-009 SHALL give flush priority over freeze: flush=1, freeze=1 -> bubble loaded.
REQ-010 SHALL, when freeze=1 and flush=0, hold every output unchanged except REQ-011 operand refresh.
REQ-011 SHALL, on a rising edge with freeze=1, valid_out=1, wb_we=1 and wb_dest==src1_out, replace val_rn_out with wb_value; likewise src2_out/val_rm_out. Both refresh on a match to both.
REQ-012 SHALL NOT refresh when valid_out=0 or freeze=0; unfrozen capture takes *_in.
REQ-013 SHALL have no combinational path from any input to any output.
REQ-014 SHALL treat imm_out=1 as val_rm_out unused; refresh of val_rm_out still performed per REQ-011.

Reset
REQ-015 SHALL, on rst=0, clear asynchronously every output to 0, valid_out=0, independent of clk.
REQ-016 SHALL, on rst release, capture normally from the first rising edge with rst=1.
REQ-017 SHALL, when reset is asserted mid-freeze, discard held state; no refresh applies.

Structure
REQ-018 SHALL take EXE_CMD encodings (MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR, CMP, TST, LDR, STR) and bubble constant from shared package arm_pkg.
REQ-019 SHALL use one sub-module, operand_hold, instantiated twice (rn, rm), for the freeze/refresh operand register.
REQ-020 SHALL place NZCV bit positions in arm_pkg.

Verification
REQ-021 SHALL cover: rst=0 with all inputs 0xFF.. -> all outputs 0, valid_out=0 before any clk edge.
REQ-022 SHALL cover: pc_in=0x10, val_rn_in=5, dest_in=3, wb_en_in=1, freeze=0 -> next cycle pc_out=0x10, val_rn_out=5, dest_out=3, wb_en_out=1, valid_out=1.
REQ-023 SHALL cover: captured src1_out=2, val_rn_out=7; freeze=1 with wb_we=1, wb_dest=2, wb_value=0x99 -> val_rn_out=0x99, other outputs unchanged.
REQ-024 SHALL cover: src1_out=src2_out=4, freeze=1, wb_dest=4, wb_value=0xAB -> val_rn_out=val_rm_out=0xAB.
REQ-025 SHALL cover: flush=1 with freeze=1, mem_w_en_in=1 -> mem_w_en_out=0, wb_en_out=0, valid_out=0 next cycle.
REQ-026 SHALL cover: rst=0 pulse between clk edges while frozen with pending wb_we match -> outputs 0 immediately; no refresh after release.

Source files
------------

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM pipeline encodings: EXE_CMD values, NZCV positions, control bundle
package arm_pkg;

  localparam int EXE_CMD_W = 4;

  localparam logic [EXE_CMD_W-1:0] EXE_NOP = 4'b0000;
  localparam logic [EXE_CMD_W-1:0] EXE_MOV = 4'b0001;
  localparam logic [EXE_CMD_W-1:0] EXE_MVN = 4'b1001;
  localparam logic [EXE_CMD_W-1:0] EXE_ADD = 4'b0010;
  localparam logic [EXE_CMD_W-1:0] EXE_ADC = 4'b0011;
  localparam logic [EXE_CMD_W-1:0] EXE_SUB = 4'b0100;
  localparam logic [EXE_CMD_W-1:0] EXE_SBC = 4'b0101;
  localparam logic [EXE_CMD_W-1:0] EXE_AND = 4'b0110;
  localparam logic [EXE_CMD_W-1:0] EXE_ORR = 4'b0111;
  localparam logic [EXE_CMD_W-1:0] EXE_EOR = 4'b1000;
  // CMP/TST reuse the ALU op of SUB/AND; LDR/STR use ADD for address generation.
  localparam logic [EXE_CMD_W-1:0] EXE_CMP = 4'b0100;
  localparam logic [EXE_CMD_W-1:0] EXE_TST = 4'b0110;
  localparam logic [EXE_CMD_W-1:0] EXE_LDR = 4'b0010;
  localparam logic [EXE_CMD_W-1:0] EXE_STR = 4'b0010;

  localparam int STATUS_N = 3;
  localparam int STATUS_Z = 2;
  localparam int STATUS_C = 1;
  localparam int STATUS_V = 0;

  typedef struct packed {
    logic mem_r_en;
    logic mem_w_en;
    logic wb_en;
    logic s;
    logic b;
    logic imm;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/operand_hold.sv
// rtl/operand_hold.sv - operand register that holds under freeze and refreshes from write-back
module operand_hold
  import arm_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               freeze_i,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic [RADDR_W-1:0] src_i,
  input  logic [RADDR_W-1:0] wb_dest_i,
  input  logic [DATA_W-1:0]  wb_value_i,
  input  logic               wb_we_i,
  input  logic [DATA_W-1:0]  d_i,
  output logic [DATA_W-1:0]  q_o
);

  logic [DATA_W-1:0] val_q, val_d;
  logic              hit;

  // src_i is the already-latched register index, so a stalled instruction
  // picks up results that retire while it waits.
  assign hit = valid_i && wb_we_i && (wb_dest_i == src_i);

  always_comb begin
    val_d = val_q;
    if (flush_i) begin
      val_d = '0;
    end else if (freeze_i) begin
      if (hit) begin
        val_d = wb_value_i;
      end
    end else begin
      val_d = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q_o = val_q;

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with freeze, flush bubble and operand refresh
module id_ex_reg
  import arm_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic [DATA_W-1:0]  pc_in,
  input  logic [DATA_W-1:0]  val_rn_in,
  input  logic [DATA_W-1:0]  val_rm_in,
  input  logic [RADDR_W-1:0] src1_in,
  input  logic [RADDR_W-1:0] src2_in,
  input  logic [RADDR_W-1:0] dest_in,
  input  logic [3:0]         exe_cmd_in,
  input  logic               mem_r_en_in,
  input  logic               mem_w_en_in,
  input  logic               wb_en_in,
  input  logic               s_in,
  input  logic               b_in,
  input  logic               imm_in,
  input  logic [11:0]        shift_operand_in,
  input  logic [23:0]        signed_imm24_in,
  input  logic [3:0]         status_in,
  input  logic [RADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0]  wb_value,
  input  logic               wb_we,
  output logic [DATA_W-1:0]  pc_out,
  output logic [DATA_W-1:0]  val_rn_out,
  output logic [DATA_W-1:0]  val_rm_out,
  output logic [RADDR_W-1:0] src1_out,
  output logic [RADDR_W-1:0] src2_out,
  output logic [RADDR_W-1:0] dest_out,
  output logic [3:0]         exe_cmd_out,
  output logic               mem_r_en_out,
  output logic               mem_w_en_out,
  output logic               wb_en_out,
  output logic               s_out,
  output logic               b_out,
  output logic               imm_out,
  output logic [11:0]        shift_operand_out,
  output logic [23:0]        signed_imm24_out,
  output logic [3:0]         status_out,
  output logic               valid_out
);

  logic [DATA_W-1:0]  pc_q, pc_d;
  logic [RADDR_W-1:0] src1_q, src1_d;
  logic [RADDR_W-1:0] src2_q, src2_d;
  logic [RADDR_W-1:0] dest_q, dest_d;
  logic [3:0]         exe_cmd_q, exe_cmd_d;
  logic [11:0]        shift_operand_q, shift_operand_d;
  logic [23:0]        signed_imm24_q, signed_imm24_d;
  logic [3:0]         status_q, status_d;
  ctrl_t              ctrl_q, ctrl_d;
  logic               valid_q, valid_d;
  ctrl_t              ctrl_in;

  assign ctrl_in = '{mem_r_en: mem_r_en_in, mem_w_en: mem_w_en_in, wb_en: wb_en_in,
                     s: s_in, b: b_in, imm: imm_in};

  // Flush wins over freeze so a squashed instruction can never stay parked here.
  always_comb begin
    pc_d            = pc_q;
    src1_d          = src1_q;
    src2_d          = src2_q;
    dest_d          = dest_q;
    exe_cmd_d       = exe_cmd_q;
    shift_operand_d = shift_operand_q;
    signed_imm24_d  = signed_imm24_q;
    status_d        = status_q;
    ctrl_d          = ctrl_q;
    valid_d         = valid_q;
    if (flush) begin
      pc_d            = '0;
      src1_d          = '0;
      src2_d          = '0;
      dest_d          = '0;
      exe_cmd_d       = EXE_NOP;
      shift_operand_d = '0;
      signed_imm24_d  = '0;
      status_d        = '0;
      ctrl_d          = CTRL_BUBBLE;
      valid_d         = 1'b0;
    end else if (!freeze) begin
      pc_d            = pc_in;
      src1_d          = src1_in;
      src2_d          = src2_in;
      dest_d          = dest_in;
      exe_cmd_d       = exe_cmd_in;
      shift_operand_d = shift_operand_in;
      signed_imm24_d  = signed_imm24_in;
      status_d        = status_in;
      ctrl_d          = ctrl_in;
      valid_d         = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q            <= '0;
      src1_q          <= '0;
      src2_q          <= '0;
      dest_q          <= '0;
      exe_cmd_q       <= EXE_NOP;
      shift_operand_q <= '0;
      signed_imm24_q  <= '0;
      status_q        <= '0;
      ctrl_q          <= CTRL_BUBBLE;
      valid_q         <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      src1_q          <= src1_d;
      src2_q          <= src2_d;
      dest_q          <= dest_d;
      exe_cmd_q       <= exe_cmd_d;
      shift_operand_q <= shift_operand_d;
      signed_imm24_q  <= signed_imm24_d;
      status_q        <= status_d;
      ctrl_q          <= ctrl_d;
      valid_q         <= valid_d;
    end
  end

  // val_rm is refreshed even for immediate forms; the EX stage ignores it then.
  operand_hold #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_rn (
    .clk_i      (clk),
    .rst_ni     (rst),
    .freeze_i   (freeze),
    .flush_i    (flush),
    .valid_i    (valid_q),
    .src_i      (src1_q),
    .wb_dest_i  (wb_dest),
    .wb_value_i (wb_value),
    .wb_we_i    (wb_we),
    .d_i        (val_rn_in),
    .q_o        (val_rn_out)
  );

  operand_hold #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_rm (
    .clk_i      (clk),
    .rst_ni     (rst),
    .freeze_i   (freeze),
    .flush_i    (flush),
    .valid_i    (valid_q),
    .src_i      (src2_q),
    .wb_dest_i  (wb_dest),
    .wb_value_i (wb_value),
    .wb_we_i    (wb_we),
    .d_i        (val_rm_in),
    .q_o        (val_rm_out)
  );

  assign pc_out            = pc_q;
  assign src1_out          = src1_q;
  assign src2_out          = src2_q;
  assign dest_out          = dest_q;
  assign exe_cmd_out       = exe_cmd_q;
  assign shift_operand_out = shift_operand_q;
  assign signed_imm24_out  = signed_imm24_q;
  assign status_out        = status_q;
  assign mem_r_en_out      = ctrl_q.mem_r_en;
  assign mem_w_en_out      = ctrl_q.mem_w_en;
  assign wb_en_out         = ctrl_q.wb_en;
  assign s_out             = ctrl_q.s;
  assign b_out             = ctrl_q.b;
  assign imm_out           = ctrl_q.imm;
  assign valid_out         = valid_q;

endmodule
